store_narrower: RTL

- Store-side counterpart of the load-path 16→32 extender: narrows a 32-bit register value to byte, halfword or word and writes it into word-only data memory.
- Byte and halfword stores run a read-modify-write (RMW) sequence because the memory has no byte enables.
- Sits between the datapath store port and the data memory; the controller stalls on busy.

---
 rtl/store_pkg.sv | 33 +++
 rtl/store_narrower_if.sv | 33 +++
 rtl/store_lane_merge.sv | 41 ++++
 rtl/store_narrower.sv | 115 +++++++++++
 4 files changed

// File: rtl/store_pkg.sv
// rtl/store_pkg.sv - shared constants, state enum and request check for the store narrower
// Contents:
//   SIZE_BYTE / SIZE_HALF / SIZE_WORD : encodings of the size input (2'b11 is reserved)
//   state_e                           : store sequencer states
//   req_bad()                         : misaligned or reserved-size request check
package store_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        MERGE = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4,
        ERR   = 3'd5
    } state_e;

    // A request is rejected when it is misaligned for its size or uses the reserved size.
    function automatic logic req_bad(input logic [1:0] sz, input logic [1:0] lane);
        logic bad;
        case (sz)
            SIZE_BYTE: bad = 1'b0;
            SIZE_HALF: bad = lane[0];
            SIZE_WORD: bad = (lane != 2'b00);
            default:   bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/store_narrower_if.sv
// rtl/store_narrower_if.sv - word-only data memory port used by the store narrower
// Signals:
//   mem_addr  : word address (byte address bits ADDR_W-1:2)
//   mem_rd_en : read strobe; mem_rdata is valid the following cycle
//   mem_rdata : read data returned by the memory
//   mem_we    : write strobe
//   mem_wdata : full word to write
// Modports: master (store narrower side), slave (memory side).
interface store_narrower_if #(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-3:0] mem_addr;
    logic              mem_rd_en;
    logic [31:0]       mem_rdata;
    logic              mem_we;
    logic [31:0]       mem_wdata;

    modport master (
        output mem_addr,
        output mem_rd_en,
        output mem_we,
        output mem_wdata,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr,
        input  mem_rd_en,
        input  mem_we,
        input  mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/store_lane_merge.sv
// rtl/store_lane_merge.sv - replaces the addressed byte or halfword lane of a memory word
// Parameters: BIG_ENDIAN (0: byte lane 0 is bits 7:0, 1: byte lane 0 is bits 31:24)
// Ports:
//   old_word : word read back from memory
//   wdata    : register value; low byte / low half used for narrow stores
//   size     : store size encoding
//   lane     : byte address bits 1:0
//   merged   : word to write back; untouched bytes equal old_word
module store_lane_merge
    import store_pkg::*;
#(
    parameter bit BIG_ENDIAN = 1'b0
) (
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    input  logic [1:0]  size,
    input  logic [1:0]  lane,
    output logic [31:0] merged
);

    logic [1:0] byte_lane;
    logic       half_hi;

    always_comb begin
        merged    = old_word;
        // Big-endian mirrors the lane index: byte k lands at physical lane 3-k,
        // and the two halfword lanes swap.
        byte_lane = BIG_ENDIAN ? ~lane : lane;
        half_hi   = BIG_ENDIAN ? ~lane[1] : lane[1];
        case (size)
            SIZE_BYTE: merged[{byte_lane, 3'b000} +: 8] = wdata[7:0];
            SIZE_HALF: begin
                if (half_hi) merged[31:16] = wdata[15:0];
                else         merged[15:0]  = wdata[15:0];
            end
            SIZE_WORD: merged = wdata;
            default:   merged = old_word;
        endcase
    end

endmodule

// File: rtl/store_narrower.sv
// rtl/store_narrower.sv - narrows a 32-bit store to byte/half/word on a word-only memory
// Parameters: ADDR_W (byte address width), BIG_ENDIAN (lane order)
// Ports:
//   clk, reset       : clock and synchronous active-high reset
//   start            : store request, sampled only in IDLE
//   size, addr, wdata: request fields, latched when the request is accepted
//   busy             : high whenever the sequencer is not IDLE
//   done             : one-cycle pulse when a store completes
//   err              : one-cycle pulse for a misaligned or reserved-size request
//   mem              : word memory port (master side)
module store_narrower
    import store_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter bit BIG_ENDIAN = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        size,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    store_narrower_if.master  mem
);

    state_e            state_q,     state_d;
    logic [ADDR_W-3:0] mem_addr_q,  mem_addr_d;
    logic [1:0]        size_q,      size_d;
    logic [1:0]        lane_q,      lane_d;
    logic [31:0]       wdata_q,     wdata_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [31:0]       merged;

    // Merge works on the read data that arrives during MERGE and the latched request.
    store_lane_merge #(
        .BIG_ENDIAN (BIG_ENDIAN)
    ) u_lane_merge (
        .old_word (mem.mem_rdata),
        .wdata    (wdata_q),
        .size     (size_q),
        .lane     (lane_q),
        .merged   (merged)
    );

    always_comb begin
        state_d     = state_q;
        mem_addr_d  = mem_addr_q;
        size_d      = size_q;
        lane_d      = lane_q;
        wdata_d     = wdata_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (req_bad(size, addr[1:0])) begin
                        // Rejected requests leave the memory-side registers untouched.
                        state_d = ERR;
                    end else begin
                        mem_addr_d = addr[ADDR_W-1:2];
                        size_d     = size;
                        lane_d     = addr[1:0];
                        wdata_d    = wdata;
                        if (size == SIZE_WORD) begin
                            // Full-word stores need no read-back.
                            mem_wdata_d = wdata;
                            state_d     = WRITE;
                        end else begin
                            state_d = READ;
                        end
                    end
                end
            end
            READ:  state_d = MERGE;
            MERGE: begin
                mem_wdata_d = merged;
                state_d     = WRITE;
            end
            WRITE: state_d = DONE;
            DONE:  state_d = IDLE;
            ERR:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            mem_addr_q  <= '0;
            size_q      <= SIZE_BYTE;
            lane_q      <= 2'b00;
            wdata_q     <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            mem_addr_q  <= mem_addr_d;
            size_q      <= size_d;
            lane_q      <= lane_d;
            wdata_q     <= wdata_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // Strobes are decoded from state only, so nothing follows start combinationally.
    assign busy          = (state_q != IDLE);
    assign done          = (state_q == DONE);
    assign err           = (state_q == ERR);
    assign mem.mem_rd_en = (state_q == READ);
    assign mem.mem_we    = (state_q == WRITE);
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_wdata = mem_wdata_q;

endmodule
